// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-channel fixed-point MAC array.
// Holds the default fixed-point word type, the FSM state enum and the saturating clip.
package mac_pkg;

    localparam int unsigned DW_DEF = 22;
    localparam int unsigned SAT_W  = 64;

    typedef logic signed [DW_DEF-1:0] fx_t;

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

    // Clip a sign-extended accumulator to a signed i_dw-bit range; returns {flag, value}.
    function automatic logic [SAT_W:0] fx_sat(input logic signed [SAT_W-1:0] i_val,
                                              input int unsigned i_dw);
        logic signed [SAT_W-1:0] v_max;
        logic signed [SAT_W-1:0] v_min;
        v_max = (64'sd1 <<< (i_dw - 1)) - 64'sd1;
        v_min = -v_max - 64'sd1;
        if (i_val > v_max) begin
            return {1'b1, v_max};
        end else if (i_val < v_min) begin
            return {1'b1, v_min};
        end
        return {1'b0, i_val};
    endfunction

endpackage

// File: rtl/mac_mul_q.sv
// Registered signed fixed-point multiplier: product floored back to WGHT_FRC fraction bits.
// Single output register so the multiply maps onto a DSP with its pipeline register.
module mac_mul_q #(
    parameter int unsigned WGHT_INT = 6,
    parameter int unsigned WGHT_FRC = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [WGHT_INT+WGHT_FRC-1:0]           i_a,
    input  logic [WGHT_INT+WGHT_FRC-1:0]           i_b,
    output logic [2*(WGHT_INT+WGHT_FRC)-WGHT_FRC-1:0] o_p
);

    localparam int unsigned DW     = WGHT_INT + WGHT_FRC;
    localparam int unsigned PROD_W = 2 * DW - WGHT_FRC;

    logic signed [2*DW-1:0]   w_full;
    logic signed [PROD_W-1:0] r_prod;

    // Arithmetic shift floors toward minus infinity, so -1 LSB * 1 LSB stays -1 LSB.
    assign w_full = $signed(i_a) * $signed(i_b);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prod <= '0;
        end else begin
            r_prod <= PROD_W'(w_full >>> WGHT_FRC);
        end
    end

    assign o_p = r_prod;

endmodule

// File: rtl/mac_array.sv
// N_CH parallel signed fixed-point MACs sharing one pixel stream; one dense-layer slice per frame.
// Bias preload on start, registered multiply, guard-bit accumulation, saturated results in DONE.
module mac_array
    import mac_pkg::*;
#(
    parameter int unsigned WGHT_INT = 6,
    parameter int unsigned WGHT_FRC = 16,
    parameter int unsigned DEPTH    = 784,
    parameter int unsigned N_CH     = 10
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic [N_CH*(WGHT_INT+WGHT_FRC)-1:0]       i_bias_in,
    input  logic                                      i_in_valid,
    output logic                                      o_in_ready,
    input  logic [WGHT_INT+WGHT_FRC-1:0]              i_din,
    input  logic [N_CH*(WGHT_INT+WGHT_FRC)-1:0]       i_w_in,
    output logic                                      o_out_valid,
    input  logic                                      i_out_ready,
    output logic [N_CH*(WGHT_INT+WGHT_FRC)-1:0]       o_mac_out,
    output logic [N_CH-1:0]                           o_sat,
    output logic                                      o_busy
);

    localparam int unsigned DW     = WGHT_INT + WGHT_FRC;
    localparam int unsigned PROD_W = 2 * DW - WGHT_FRC;
    localparam int unsigned ACC_W  = 2 * DW - WGHT_FRC + $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    state_e                   r_state;
    state_e                   w_state_d;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc     [N_CH];
    logic signed [ACC_W-1:0]  w_prod_x  [N_CH];
    logic signed [ACC_W-1:0]  w_bias_x  [N_CH];
    logic [PROD_W-1:0]        w_prod    [N_CH];
    logic [SAT_W:0]           w_sat_res [N_CH];
    logic                     w_accept;
    logic                     w_load;

    assign w_accept = i_in_valid && (r_state == StAccum);
    assign w_load   = i_start && (r_state == StIdle);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StAccum;
            StAccum: if (w_accept && (r_cnt == LAST_CNT)) w_state_d = StDrain;
            StDrain: w_state_d = StDone;
            StDone:  if (i_out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_prod_vld <= 1'b0;
            for (int k = 0; k < int'(N_CH); k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            r_state    <= w_state_d;
            r_prod_vld <= w_accept;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int k = 0; k < int'(N_CH); k++) begin
                if (w_load) begin
                    r_acc[k] <= w_bias_x[k];
                end else if (r_prod_vld) begin
                    r_acc[k] <= r_acc[k] + w_prod_x[k];
                end
            end
        end
    end

    for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
        mac_mul_q #(
            .WGHT_INT (WGHT_INT),
            .WGHT_FRC (WGHT_FRC)
        ) u_mul (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_a     (i_din),
            .i_b     (i_w_in[k*DW +: DW]),
            .o_p     (w_prod[k])
        );

        assign w_prod_x[k]  = {{(ACC_W-PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
        assign w_bias_x[k]  = {{(ACC_W-DW){i_bias_in[k*DW+DW-1]}}, i_bias_in[k*DW +: DW]};
        assign w_sat_res[k] = fx_sat({{(SAT_W-ACC_W){r_acc[k][ACC_W-1]}}, r_acc[k]}, DW);

        assign o_mac_out[k*DW +: DW] = (r_state == StDone) ? DW'(w_sat_res[k]) : '0;
        assign o_sat[k]              = (r_state == StDone) && w_sat_res[k][SAT_W];
    end

    assign o_in_ready  = (r_state == StAccum);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mac_array.sv
// Directed and random frames for mac_array (DEPTH=4, N_CH=2) against an arithmetic reference model.
module tb_mac_array;

    localparam int DW = 22;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [43:0]   bias_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [21:0]   din = '0;
    logic [43:0]   w_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [43:0]   mac_out;
    logic [1:0]    sat;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [21:0] st_din [NB];
    logic [21:0] st_w0  [NB];
    logic [21:0] st_w1  [NB];
    logic [21:0] st_b0;
    logic [21:0] st_b1;

    mac_array #(
        .WGHT_INT (6),
        .WGHT_FRC (16),
        .DEPTH    (4),
        .N_CH     (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_bias_in   (bias_in),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_din       (din),
        .i_w_in      (w_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_mac_out   (mac_out),
        .o_sat       (sat),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [21:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: bias + sum of floor(din*w / 2^16), then clip to 22-bit signed.
    function automatic void model_ch(input int ch, output logic [21:0] res, output logic s);
        longint acc;
        longint p;
        acc = sx(ch == 0 ? st_b0 : st_b1);
        for (int i = 0; i < NB; i++) begin
            p = sx(st_din[i]) * sx(ch == 0 ? st_w0[i] : st_w1[i]);
            acc += p >>> 16;
        end
        s = 1'b1;
        if (acc > 64'sd2097151) res = 22'h1FFFFF;
        else if (acc < -64'sd2097152) res = 22'h200000;
        else begin
            res = acc[21:0];
            s = 1'b0;
        end
    endfunction

    task automatic set_const(input logic [21:0] b0, input logic [21:0] b1, input logic [21:0] d,
                             input logic [21:0] w0, input logic [21:0] w1);
        st_b0 = b0;
        st_b1 = b1;
        for (int i = 0; i < NB; i++) begin
            st_din[i] = d;
            st_w0[i]  = w0;
            st_w1[i]  = w1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive_beat(input int i);
        din  = st_din[i];
        w_in = {st_w1[i], st_w0[i]};
    endtask

    // One full frame with optional bubbles, output stall and ignored start pulses.
    task automatic run_frame(input string tag, input bit toggle, input int stall,
                             input bit pulse_start, input bit idle_valid);
        logic [21:0] e0, e1;
        logic        s0, s1;
        logic [43:0] held;
        int          nacc;
        int          cyc;
        bit          rdy;
        model_ch(0, e0, s0);
        model_ch(1, e1, s1);
        bias_in = {st_b1, st_b0};
        if (idle_valid) begin
            in_valid = 1'b1;
            drive_beat(0);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ready_accum"}, {63'd0, in_ready}, 64'd1);
        nacc = 0;
        cyc  = 0;
        while (nacc < NB && cyc < 40) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            drive_beat(nacc);
            start = pulse_start && (cyc == 1);
            rdy = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (in_valid && rdy) nacc++;
            cyc++;
        end
        in_valid = 1'b0;
        if (nacc < NB) chk({tag, "_accept_timeout"}, 64'(nacc), 64'(NB));
        chk({tag, "_drain_novalid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_drain_noready"}, {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_ch0"}, 64'(mac_out[21:0]), 64'(e0));
        chk({tag, "_ch1"}, 64'(mac_out[43:22]), 64'(e1));
        chk({tag, "_sat"}, 64'(sat), 64'({s1, s0}));
        held = mac_out;
        for (int s = 0; s < stall; s++) begin
            start = pulse_start && (s == 0);
            @(posedge clk); #1;
            start = 1'b0;
            chk({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, "_stall_data"}, 64'(mac_out), 64'(held));
            chk({tag, "_stall_noready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        start = pulse_start;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_idle_out"}, {19'd0, mac_out, sat, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_stay_idle"}, {62'd0, busy, in_ready}, 64'd0);
    endtask

    initial begin
        do_reset();
        chk("reset_flags", {61'd0, busy, in_ready, out_valid}, 64'd0);
        chk("reset_out", {18'd0, mac_out, sat}, 64'd0);

        set_const(22'h0, 22'h0, 22'h010000, 22'h008000, 22'h3F0000);
        run_frame("c1", 1'b0, 0, 1'b0, 1'b0);

        set_const(22'h0, 22'h0, 22'h1F0000, 22'h1F0000, 22'h210000);
        run_frame("c2", 1'b0, 0, 1'b0, 1'b0);

        set_const(22'h0, 22'h0, 22'h010000, 22'h008000, 22'h3F0000);
        run_frame("c3", 1'b1, 5, 1'b0, 1'b0);

        set_const(22'h018000, 22'h3FFFFF, 22'h0, 22'h123456, 22'h2ABCDE);
        run_frame("c4a", 1'b0, 0, 1'b0, 1'b0);
        set_const(22'h0, 22'h0, 22'h000001, 22'h3FFFFF, 22'h3FFFFF);
        run_frame("c4b", 1'b0, 0, 1'b0, 1'b0);

        // Reset after two accepts, then a clean frame.
        set_const(22'h0, 22'h0, 22'h010000, 22'h008000, 22'h3F0000);
        bias_in = 44'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        drive_beat(0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("c5_reset_flags", {61'd0, busy, in_ready, out_valid}, 64'd0);
        chk("c5_reset_out", {18'd0, mac_out, sat}, 64'd0);
        run_frame("c5", 1'b0, 0, 1'b0, 1'b0);

        set_const(22'h000100, 22'h3FF000, 22'h010000, 22'h008000, 22'h3F0000);
        st_din[0] = 22'h020000;
        st_din[3] = 22'h3F8000;
        run_frame("c6", 1'b1, 2, 1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            st_b0 = 22'($urandom);
            st_b1 = 22'($urandom);
            for (int i = 0; i < NB; i++) begin
                st_din[i] = (r % 2 == 0) ? 22'($urandom) : 22'($signed(6'($urandom)) <<< 14);
                st_w0[i]  = 22'($urandom);
                st_w1[i]  = (r % 2 == 0) ? 22'($urandom) : 22'($signed(8'($urandom)) <<< 12);
            end
            run_frame("rnd", 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
